// File: rtl/rvfi_cov_pkg.sv
// rvfi_cov_pkg: shared category encoding and helpers for the RVFI coverage monitor.
package rvfi_cov_pkg;

    localparam int NCAT      = 6;
    localparam int CAT_LOAD  = 0;
    localparam int CAT_STORE = 1;
    localparam int CAT_LONG  = 2;
    localparam int CAT_COMPR = 3;
    localparam int CAT_XFER  = 4;
    localparam int CAT_TRAP  = 5;

    function automatic int unsigned popcount(input logic [63:0] v);
        popcount = 0;
        for (int i = 0; i < 64; i++) popcount += 32'(v[i]);
    endfunction

endpackage

// File: rtl/rvfi_cov_classify.sv
// rvfi_cov_classify: combinational category hit vector for one RVFI retirement lane.
module rvfi_cov_classify
    import rvfi_cov_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic              valid_i,
    input  logic [ILEN-1:0]   insn_i,
    input  logic              trap_i,
    input  logic [XLEN-1:0]   pc_rdata_i,
    input  logic [XLEN-1:0]   pc_wdata_i,
    input  logic [XLEN/8-1:0] rmask_i,
    input  logic [XLEN/8-1:0] wmask_i,
    output logic [NCAT-1:0]   hit_o
);

    logic            long_insn;
    logic [XLEN-1:0] pc_seq;
    logic            unused_insn;

    assign long_insn   = insn_i[1:0] == 2'b11;
    assign unused_insn = ^insn_i[ILEN-1:2];
    // Sequential successor wraps modulo 2^XLEN, so a wrapped fall-through is not a transfer.
    assign pc_seq      = pc_rdata_i + (long_insn ? XLEN'(4) : XLEN'(2));

    always_comb begin
        hit_o            = '0;
        hit_o[CAT_LOAD]  = valid_i && rmask_i != '0;
        hit_o[CAT_STORE] = valid_i && wmask_i != '0;
        hit_o[CAT_LONG]  = valid_i && long_insn;
        hit_o[CAT_COMPR] = valid_i && !long_insn;
        hit_o[CAT_XFER]  = valid_i && !trap_i && pc_wdata_i != pc_seq;
        hit_o[CAT_TRAP]  = valid_i && trap_i;
    end

endmodule

// File: rtl/rvfi_cover_monitor.sv
// rvfi_cover_monitor: saturating per-category retirement counters, goal flags,
// first-goal cycle capture and sticky rvfi_order sequencing check.
module rvfi_cover_monitor
    import rvfi_cov_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [NRET-1:0]          rvfi_valid,
    input  logic [64*NRET-1:0]       rvfi_order,
    input  logic [ILEN*NRET-1:0]     rvfi_insn,
    input  logic [NRET-1:0]          rvfi_trap,
    input  logic [XLEN*NRET-1:0]     rvfi_pc_rdata,
    input  logic [XLEN*NRET-1:0]     rvfi_pc_wdata,
    input  logic [XLEN/8*NRET-1:0]   rvfi_mem_rmask,
    input  logic [XLEN/8*NRET-1:0]   rvfi_mem_wmask,
    input  logic [CNT_W*NCAT-1:0]    threshold,
    output logic [CNT_W*NCAT-1:0]    count,
    output logic [NCAT-1:0]          cat_hit,
    output logic                     all_hit,
    output logic [CYC_W-1:0]         hit_cycle,
    output logic                     hit_seen,
    output logic                     order_err
);

    logic [NRET-1:0][NCAT-1:0]  lane_hit;
    logic [NCAT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCAT-1:0]            cat_q, cat_d;
    logic                       all_q, hseen_q, err_q, bad;
    logic [CYC_W-1:0]           cyc_q, cyc_d, hcyc_q;
    logic [63:0]                exp_q, exp_d, last_ord;

    for (genvar k = 0; k < NRET; k++) begin : g_lane
        rvfi_cov_classify #(.XLEN(XLEN), .ILEN(ILEN)) u_classify (
            .valid_i   (rvfi_valid[k]),
            .insn_i    (rvfi_insn[k*ILEN +: ILEN]),
            .trap_i    (rvfi_trap[k]),
            .pc_rdata_i(rvfi_pc_rdata[k*XLEN +: XLEN]),
            .pc_wdata_i(rvfi_pc_wdata[k*XLEN +: XLEN]),
            .rmask_i   (rvfi_mem_rmask[k*(XLEN/8) +: XLEN/8]),
            .wmask_i   (rvfi_mem_wmask[k*(XLEN/8) +: XLEN/8]),
            .hit_o     (lane_hit[k])
        );
    end

    for (genvar c = 0; c < NCAT; c++) begin : g_cat
        logic [63:0]    col;
        logic [CNT_W:0] sum;
        always_comb begin
            col = '0;
            for (int l = 0; l < NRET; l++) col[l] = lane_hit[l][c];
        end
        assign sum      = {1'b0, cnt_q[c]} + (CNT_W+1)'(popcount(col));
        assign cnt_d[c] = !enable ? cnt_q[c] : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        assign cat_d[c] = cnt_q[c] >= threshold[c*CNT_W +: CNT_W];
    end

    assign cyc_d = &cyc_q ? cyc_q : cyc_q + CYC_W'(1);

    // After a violation the tracker follows the core again from its highest valid lane.
    always_comb begin
        bad      = 1'b0;
        last_ord = '0;
        for (int l = 0; l < NRET; l++) begin
            if (rvfi_valid[l]) begin
                bad      = bad | (rvfi_order[l*64 +: 64] != exp_q + 64'(l));
                last_ord = rvfi_order[l*64 +: 64];
            end
        end
        for (int l = 1; l < NRET; l++) bad = bad | (rvfi_valid[l] & ~rvfi_valid[l-1]);
        exp_d = bad ? last_ord + 64'd1 : exp_q + 64'(popcount(64'(rvfi_valid)));
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            cnt_q   <= '0;
            cat_q   <= '0;
            all_q   <= 1'b0;
            cyc_q   <= '0;
            hcyc_q  <= '0;
            hseen_q <= 1'b0;
            err_q   <= 1'b0;
            exp_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            cat_q <= cat_d;
            all_q <= &cat_d;
            cyc_q <= cyc_d;
            if (!hseen_q && &cat_d) begin
                hcyc_q  <= cyc_d;
                hseen_q <= 1'b1;
            end
            err_q <= err_q | bad;
            exp_q <= exp_d;
        end
    end

    assign count     = cnt_q;
    assign cat_hit   = cat_q;
    assign all_hit   = all_q;
    assign hit_cycle = hcyc_q;
    assign hit_seen  = hseen_q;
    assign order_err = err_q;

endmodule

// File: doc/rvfi_cover_monitor.md
Name: rvfi_cover_monitor

Overview:
Parametrised RVFI retirement coverage monitor for formal cover benches and simulation.
- Classifies every retired instruction on NRET RVFI channels into fixed categories.
- Keeps saturating per-category counters and compares them against runtime thresholds.
- Reports per-category and all-category goal flags, the cycle at which all goals were first met, and a sticky rvfi_order sequencing error.
- Sits beside the core under test; connects to the flattened RVFI bus.

Parameters:
NRET, 1, retirement channels per cycle
XLEN, 32, register/memory data width (mask width XLEN/8)
ILEN, 32, instruction width per channel
CNT_W, 16, category counter width
CYC_W, 32, cycle counter width

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
clear  in  1  synchronous clear of counters, flags, cycle counter and order tracking
enable  in  1  counting enable; when 0, retirements are ignored (order tracking still runs)
rvfi_valid  in  NRET  per-channel retire valid
rvfi_order  in  64*NRET  per-channel retire order
rvfi_insn  in  ILEN*NRET  instruction word
rvfi_trap  in  NRET  trap flag
rvfi_pc_rdata  in  XLEN*NRET  pc of instruction
rvfi_pc_wdata  in  XLEN*NRET  next pc
rvfi_mem_rmask  in  XLEN/8*NRET  read mask
rvfi_mem_wmask  in  XLEN/8*NRET  write mask
threshold  in  CNT_W*NCAT  per-category goal, category c at [c*CNT_W +: CNT_W]
count  out  CNT_W*NCAT  category counters
cat_hit  out  NCAT  count[c] >= threshold[c]
all_hit  out  1  &cat_hit
hit_cycle  out  CYC_W  cycle count when all_hit first rose
hit_seen  out  1  hit_cycle is valid
order_err  out  1  sticky sequencing error

Behaviour:
- Categories (NCAT=6), per valid channel, evaluated independently; one instruction may hit several categories:
  - LOAD: rmask != 0
  - STORE: wmask != 0
  - LONG: insn[1:0] == 3
  - COMPR: insn[1:0] != 3
  - XFER: !trap && pc_wdata != pc_rdata + (LONG ? 4 : 2), modulo 2^XLEN
  - TRAP: trap
- Counter update:
  - Each cycle with enable, count[c] += number of valid channels hitting c (0..NRET).
  - Saturates at 2^CNT_W-1; no wrap.
  - Visible one cycle after the retire cycle.
- Flags:
  - cat_hit and all_hit are registered from the updated counts, one cycle after count.
  - threshold == 0 gives cat_hit=1 from the cycle after reset.
- Cycle counter:
  - Internal, increments every cycle after reset/clear, saturating.
  - On the cycle all_hit first transitions 0->1, hit_cycle captures the cycle counter and hit_seen sets.
  - Both hold until reset/clear; later drops and rises of all_hit (threshold changes) do not recapture.
- Order tracking:
  - expected_order starts at 0.
  - Valid channels must be packed from lane 0 (no valid lane above an invalid one).
  - Lane k must carry expected_order+k.
  - After the cycle, expected_order += popcount(rvfi_valid).
  - Any violation sets order_err; order_err stays set until reset/clear.
  - After an error, expected_order resyncs to (last valid lane order)+1.
- Reset (resetn=0): count=0, cat_hit=0, all_hit=0, hit_cycle=0, hit_seen=0, order_err=0, cycle counter 0, expected_order 0.
- clear has the same effect as reset. A retirement in the clear cycle is discarded, including its order check.
- Reset or clear during a retire cycle: the reset/clear value wins.
- enable=0 with valid retirements: counts hold; order still checked.

Decomposition:
- Package rvfi_cov_pkg:
  - NCAT
  - category index constants CAT_LOAD..CAT_TRAP (0..5)
  - popcount function
- Sub-module rvfi_cov_classify:
  - purely combinational, one instance per lane
  - inputs: one lane's RVFI fields
  - output: NCAT-bit hit vector
- The top module holds the adder tree, counters, flags and order state.

Test Plan:
1. NRET=1, thresholds all 1; retire lw (insn 0x0002A303, rmask=4'hF), then c.sw (insn 0xC004, wmask=4'hF), then jal with pc 0x100->0x200 -> count LOAD=1, STORE=1, LONG=2, COMPR=1, XFER=1; TRAP=0 so all_hit stays 0. Set threshold TRAP=0 -> all_hit=1 two cycles later, hit_seen=1.
2. CNT_W=4, drive 20 consecutive compressed retires -> count COMPR saturates at 15 and holds.
3. NRET=2, both lanes valid with orders 0,1 then 2,3, both long loads -> LOAD=4, LONG=4, order_err=0. Then lane 1 valid alone -> order_err=1.
4. NRET=2, orders 4,6 in one cycle -> order_err=1; next cycle orders 7,8 -> no further change, and counting continues.
5. Reach all_hit at cycle 37, then raise a threshold, then lower it at cycle 50 -> hit_cycle stays 37. Pulse clear -> all outputs 0, and the next retire at order 0 is accepted.
6. enable=0 with 5 valid retires -> counts hold; order errors are still detected. Assert resetn=0 mid-stream -> all outputs 0 next cycle.
